act_row_buffer: RTL

//  Activation row buffer that sits directly upstream of the mask (window-select) stage.

---
 rtl/act_buf_pkg.sv | 17 +
 rtl/act_bank_ram.sv | 42 ++++
 rtl/act_row_buffer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/act_buf_pkg.sv
// Shared defaults, FSM state type and address width
// for the activation row buffer.
package act_buf_pkg;

   localparam int RAM_ROW    = 33;
   localparam int DATA_WIDTH = 64;
   localparam int DEEP       = 512;
   localparam int AW         = $clog2(DEEP);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      READ,
      DRAIN
   } state_e;

endpackage

// File: rtl/act_bank_ram.sv
// One row bank: simple dual-port RAM, deep x Data_Width,
// one write port, one synchronous read port.
// Ports: clk, rst (clears read register only), we/waddr/wdata,
// re/raddr, rdata (holds its value while re is low).
module act_bank_ram
   import act_buf_pkg::*;
#(
   parameter int Data_Width = DATA_WIDTH,
   parameter int deep       = DEEP,
   parameter int Aw         = $clog2(deep)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [Aw-1:0]         waddr,
   input  logic [Data_Width-1:0] wdata,
   input  logic                  re,
   input  logic [Aw-1:0]         raddr,
   output logic [Data_Width-1:0] rdata
);

   logic [Data_Width-1:0] mem [deep];
   logic [Data_Width-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register doubles as the output holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/act_row_buffer.sv
// Activation row buffer: fills Ram_Row banks from a row-major
// stream, then replays all rows in parallel one column per beat.
// Ports: clk, rst (sync, active-high), ram_deep/start (tile
// config), s_valid/s_ready/s_data (fill stream), tready/dout_valid/
// dout (readout), busy, done, cfg_err (status pulses).
module act_row_buffer
   import act_buf_pkg::*;
#(
   parameter int Ram_Row    = RAM_ROW,
   parameter int Data_Width = DATA_WIDTH,
   parameter int deep       = DEEP
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [$clog2(deep):0]         ram_deep,
   input  logic                          start,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [Data_Width-1:0]         s_data,
   input  logic                          tready,
   output logic                          dout_valid,
   output logic [Data_Width*Ram_Row-1:0] dout,
   output logic                          busy,
   output logic                          done,
   output logic                          cfg_err
);

   localparam int CW = $clog2(deep);
   localparam int RW = (Ram_Row > 1) ? $clog2(Ram_Row) : 1;
   localparam logic [RW-1:0] ROW_LAST  = RW'(Ram_Row - 1);
   localparam logic [CW:0]   DEPTH_MAX = (CW + 1)'(deep);

   state_e        state_q, state_d;
   logic [CW-1:0] nm1_q, nm1_d;
   logic [CW-1:0] wr_col_q, wr_col_d;
   logic [CW-1:0] rd_col_q, rd_col_d;
   logic [RW-1:0] wr_row_q, wr_row_d;
   logic          dout_valid_q, dout_valid_d;
   logic          cfg_err_q, cfg_err_d;
   logic          wr_en;
   logic          rd_en;
   logic          cfg_ok;

   assign cfg_ok  = (ram_deep != '0) && (ram_deep <= DEPTH_MAX);
   assign s_ready = (state_q == FILL);
   assign wr_en   = s_ready && s_valid;
   // A read is issued only when the output slot frees, so the bank
   // read registers hold the current column through a stall.
   assign rd_en   = (state_q == READ) && (!dout_valid_q || tready);
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DRAIN) && dout_valid_q && tready;

   assign dout_valid = dout_valid_q;
   assign cfg_err    = cfg_err_q;

   always_comb begin
      state_d      = state_q;
      nm1_d        = nm1_q;
      wr_col_d     = wr_col_q;
      wr_row_d     = wr_row_q;
      rd_col_d     = rd_col_q;
      cfg_err_d    = 1'b0;
      dout_valid_d = dout_valid_q;

      if (rd_en) begin
         dout_valid_d = 1'b1;
      end else if (dout_valid_q && tready) begin
         dout_valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  nm1_d    = CW'(ram_deep - 1'b1);
                  wr_col_d = '0;
                  wr_row_d = '0;
                  rd_col_d = '0;
                  state_d  = FILL;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         FILL: begin
            if (wr_en) begin
               if (wr_col_q == nm1_q) begin
                  wr_col_d = '0;
                  if (wr_row_q == ROW_LAST) begin
                     wr_row_d = '0;
                     state_d  = READ;
                  end else begin
                     wr_row_d = wr_row_q + RW'(1);
                  end
               end else begin
                  wr_col_d = wr_col_q + CW'(1);
               end
            end
         end
         READ: begin
            if (rd_en) begin
               if (rd_col_q == nm1_q) begin
                  rd_col_d = '0;
                  state_d  = DRAIN;
               end else begin
                  rd_col_d = rd_col_q + CW'(1);
               end
            end
         end
         DRAIN: begin
            if (done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         nm1_q        <= '0;
         wr_col_q     <= '0;
         wr_row_q     <= '0;
         rd_col_q     <= '0;
         dout_valid_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         nm1_q        <= nm1_d;
         wr_col_q     <= wr_col_d;
         wr_row_q     <= wr_row_d;
         rd_col_q     <= rd_col_d;
         dout_valid_q <= dout_valid_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   for (genvar r = 0; r < Ram_Row; r++) begin : g_bank
      act_bank_ram #(
         .Data_Width (Data_Width),
         .deep       (deep),
         .Aw         (CW)
      ) u_ram (
         .clk   (clk),
         .rst   (rst),
         .we    (wr_en && (wr_row_q == RW'(r))),
         .waddr (wr_col_q),
         .wdata (s_data),
         .re    (rd_en),
         .raddr (rd_col_q),
         .rdata (dout[r*Data_Width +: Data_Width])
      );
   end

endmodule
